// File: rtl/affine_pkg.sv
// Shared state encoding, default geometry and arithmetic helpers for the
// affine sub-block motion-vector generator.
package affine_pkg;

  localparam int SB_LOG2_DEF  = 2;
  localparam int MAX_LOG2_DEF = 5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  function automatic logic signed [31:0] sat(input logic signed [31:0] value,
                                             input int width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

  // Round half up, then floor via arithmetic shift; s is always >= 1 here.
  function automatic logic signed [31:0] rnd_shift(input logic signed [31:0] v,
                                                   input int s);
    return (v + (32'sd1 <<< (s - 1))) >>> s;
  endfunction

endpackage

// File: rtl/affine_mv_eval.sv
// Combinational evaluation of one 4x4 sub-block MV from the captured
// control-point MVs, clamped block size and sub-block column/row.
module affine_mv_eval
  import affine_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_LOG2 = MAX_LOG2_DEF,
  parameter int SB_LOG2  = SB_LOG2_DEF,
  parameter int LW       = $clog2(MAX_LOG2 + 1),
  parameter int IW       = (MAX_LOG2 - SB_LOG2 < 1) ? 1 : MAX_LOG2 - SB_LOG2
) (
  input  logic                    mode6,
  input  logic [LW-1:0]           log2_w,
  input  logic [LW-1:0]           log2_h,
  input  logic signed [WIDTH-1:0] mv0_h,
  input  logic signed [WIDTH-1:0] mv0_v,
  input  logic signed [WIDTH-1:0] mv1_h,
  input  logic signed [WIDTH-1:0] mv1_v,
  input  logic signed [WIDTH-1:0] mv2_h,
  input  logic signed [WIDTH-1:0] mv2_v,
  input  logic [IW-1:0]           sx,
  input  logic [IW-1:0]           sy,
  output logic signed [WIDTH-1:0] mv_h,
  output logic signed [WIDTH-1:0] mv_v
);

  localparam int PW = WIDTH + MAX_LOG2 + 3;
  localparam int SW = PW + 2;
  localparam int CW = MAX_LOG2 + 1;
  localparam logic [SB_LOG2-1:0] HALF_SB = SB_LOG2'(1 << (SB_LOG2 - 1));

  logic signed [WIDTH:0] dhx, dhy, dvx, dvy;
  logic [LW-1:0]         ly;
  logic [CW-1:0]         xc, yc;
  logic signed [PW-1:0]  p_hx, p_vx, p_hy, p_vy;
  logic signed [SW-1:0]  sum_h, sum_v;

  always_comb begin
    dhx = (WIDTH+1)'(mv1_h) - (WIDTH+1)'(mv0_h);
    dhy = (WIDTH+1)'(mv1_v) - (WIDTH+1)'(mv0_v);
    // The 4-parameter model is a rotation/zoom: the vertical gradient is the
    // horizontal one turned by 90 degrees and scales with the block width.
    if (mode6) begin
      dvx = (WIDTH+1)'(mv2_h) - (WIDTH+1)'(mv0_h);
      dvy = (WIDTH+1)'(mv2_v) - (WIDTH+1)'(mv0_v);
      ly  = log2_h;
    end else begin
      dvx = -dhy;
      dvy = dhx;
      ly  = log2_w;
    end
    xc = CW'({sx, HALF_SB});
    yc = CW'({sy, HALF_SB});

    p_hx = PW'(dhx) * PW'($signed({1'b0, xc}));
    p_vx = PW'(dvx) * PW'($signed({1'b0, yc}));
    p_hy = PW'(dhy) * PW'($signed({1'b0, xc}));
    p_vy = PW'(dvy) * PW'($signed({1'b0, yc}));

    sum_h = SW'(mv0_h) + SW'(rnd_shift(32'(p_hx), int'(log2_w)))
                       + SW'(rnd_shift(32'(p_vx), int'(ly)));
    sum_v = SW'(mv0_v) + SW'(rnd_shift(32'(p_hy), int'(log2_w)))
                       + SW'(rnd_shift(32'(p_vy), int'(ly)));

    mv_h = WIDTH'(sat(32'(sum_h), WIDTH));
    mv_v = WIDTH'(sat(32'(sum_v), WIDTH));
  end

endmodule

// File: rtl/affine_subblock_mv_gen.sv
// Accepts one affine block descriptor, then streams one saturated MV per
// 4x4 sub-block in raster order with valid/ready flow control.
module affine_subblock_mv_gen
  import affine_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_LOG2 = MAX_LOG2_DEF,
  parameter int SB_LOG2  = SB_LOG2_DEF,
  parameter int LW       = $clog2(MAX_LOG2 + 1),
  parameter int IW       = (MAX_LOG2 - SB_LOG2 < 1) ? 1 : MAX_LOG2 - SB_LOG2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_mode6,
  input  logic [LW-1:0]           in_log2_w,
  input  logic [LW-1:0]           in_log2_h,
  input  logic signed [WIDTH-1:0] in_mv0_h,
  input  logic signed [WIDTH-1:0] in_mv0_v,
  input  logic signed [WIDTH-1:0] in_mv1_h,
  input  logic signed [WIDTH-1:0] in_mv1_v,
  input  logic signed [WIDTH-1:0] in_mv2_h,
  input  logic signed [WIDTH-1:0] in_mv2_v,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_mv_h,
  output logic signed [WIDTH-1:0] out_mv_v,
  output logic [IW-1:0]           out_sb_x,
  output logic [IW-1:0]           out_sb_y,
  output logic                    out_last
);

  logic [1:0]              state_r;
  logic                    mode6_p0;
  logic [LW-1:0]           lw_p0, lh_p0;
  logic signed [WIDTH-1:0] mv0_h_p0, mv0_v_p0, mv1_h_p0, mv1_v_p0, mv2_h_p0, mv2_v_p0;
  logic [IW-1:0]           sx_p0, sy_p0;
  logic [IW-1:0]           sx_max, sy_max;
  logic signed [WIDTH-1:0] eval_mv_h, eval_mv_v;
  logic                    load, last_sb;

  function automatic logic [LW-1:0] clamp_log2(input logic [LW-1:0] l);
    if (l < LW'(SB_LOG2))  return LW'(SB_LOG2);
    if (l > LW'(MAX_LOG2)) return LW'(MAX_LOG2);
    return l;
  endfunction

  assign in_ready = (state_r == ST_IDLE) && !rst;
  assign load     = (state_r == ST_RUN) && (!out_valid || out_ready);
  assign sx_max   = IW'((1 << (lw_p0 - LW'(SB_LOG2))) - 1);
  assign sy_max   = IW'((1 << (lh_p0 - LW'(SB_LOG2))) - 1);
  assign last_sb  = (sx_p0 == sx_max) && (sy_p0 == sy_max);

  // Stage p0: descriptor capture, held for the whole block
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      mode6_p0 <= in_mode6;
      lw_p0    <= clamp_log2(in_log2_w);
      lh_p0    <= clamp_log2(in_log2_h);
      mv0_h_p0 <= in_mv0_h;
      mv0_v_p0 <= in_mv0_v;
      mv1_h_p0 <= in_mv1_h;
      mv1_v_p0 <= in_mv1_v;
      mv2_h_p0 <= in_mv2_h;
      mv2_v_p0 <= in_mv2_v;
    end
  end

  affine_mv_eval #(
    .WIDTH(WIDTH), .MAX_LOG2(MAX_LOG2), .SB_LOG2(SB_LOG2), .LW(LW), .IW(IW)
  ) u_eval (
    .mode6 (mode6_p0),
    .log2_w(lw_p0),
    .log2_h(lh_p0),
    .mv0_h (mv0_h_p0),
    .mv0_v (mv0_v_p0),
    .mv1_h (mv1_h_p0),
    .mv1_v (mv1_v_p0),
    .mv2_h (mv2_h_p0),
    .mv2_v (mv2_v_p0),
    .sx    (sx_p0),
    .sy    (sy_p0),
    .mv_h  (eval_mv_h),
    .mv_v  (eval_mv_v)
  );

  // Stage p1: sequencing and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      sx_p0     <= '0;
      sy_p0     <= '0;
      out_valid <= 1'b0;
      out_mv_h  <= '0;
      out_mv_v  <= '0;
      out_sb_x  <= '0;
      out_sb_y  <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            state_r <= ST_RUN;
            sx_p0   <= '0;
            sy_p0   <= '0;
          end
        end
        ST_RUN: begin
          if (load) begin
            out_valid <= 1'b1;
            out_mv_h  <= eval_mv_h;
            out_mv_v  <= eval_mv_v;
            out_sb_x  <= sx_p0;
            out_sb_y  <= sy_p0;
            out_last  <= last_sb;
            if (last_sb) begin
              state_r <= ST_DRAIN;
              sx_p0   <= '0;
              sy_p0   <= '0;
            end else if (sx_p0 == sx_max) begin
              sx_p0 <= '0;
              sy_p0 <= sy_p0 + 1'b1;
            end else begin
              sx_p0 <= sx_p0 + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state_r   <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_affine_subblock_mv_gen.sv
// Bench for affine_subblock_mv_gen: directed scenarios plus randomized
// descriptors, all outputs compared against an integer affine model.
module tb_affine_subblock_mv_gen;

  localparam int WIDTH = 8;
  localparam int LW    = 3;
  localparam int IW    = 3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid, in_ready, in_mode6;
  logic [LW-1:0]           in_log2_w, in_log2_h;
  logic signed [WIDTH-1:0] in_mv0_h, in_mv0_v, in_mv1_h, in_mv1_v, in_mv2_h, in_mv2_v;
  logic                    out_valid, out_ready, out_last;
  logic signed [WIDTH-1:0] out_mv_h, out_mv_v;
  logic [IW-1:0]           out_sb_x, out_sb_y;

  always #5 clk = ~clk;

  affine_subblock_mv_gen dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode6(in_mode6),
    .in_log2_w(in_log2_w), .in_log2_h(in_log2_h),
    .in_mv0_h(in_mv0_h), .in_mv0_v(in_mv0_v),
    .in_mv1_h(in_mv1_h), .in_mv1_v(in_mv1_v),
    .in_mv2_h(in_mv2_h), .in_mv2_v(in_mv2_v),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mv_h(out_mv_h), .out_mv_v(out_mv_v),
    .out_sb_x(out_sb_x), .out_sb_y(out_sb_y), .out_last(out_last)
  );

  typedef struct {
    bit mode6;
    int lw, lh, m0h, m0v, m1h, m1v, m2h, m2v;
  } desc_t;

  typedef struct {
    int h, v, sx, sy, c;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  exp_t obs_q[$];
  int   n_checks = 0, n_fail = 0;
  int   cyc = 0, last_out_cyc = -100, last_gap = 0, stall_cnt = 0;
  int   rmode = 0;

  function automatic void check(string name, int act, int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic int clampl(int l);
    if (l < 2) return 2;
    if (l > 5) return 5;
    return l;
  endfunction

  // Round half up to a multiple of 2^s, result is floor((v + 2^(s-1)) / 2^s)
  function automatic int floor_rnd(int v, int s);
    int d = 1 << s;
    int q = v + d / 2;
    if (q >= 0) return q / d;
    return -((-q + d - 1) / d);
  endfunction

  function automatic int sat8(int x);
    if (x > 127) return 127;
    if (x < -128) return -128;
    return x;
  endfunction

  function automatic void model(input desc_t d, input int sx, input int sy,
                                output int h, output int v);
    int lw = clampl(d.lw);
    int lh = clampl(d.lh);
    int dhx = d.m1h - d.m0h;
    int dhy = d.m1v - d.m0v;
    int dvx, dvy, ly;
    int xc = 4 * sx + 2;
    int yc = 4 * sy + 2;
    if (d.mode6) begin
      dvx = d.m2h - d.m0h; dvy = d.m2v - d.m0v; ly = lh;
    end else begin
      dvx = -dhy; dvy = dhx; ly = lw;
    end
    h = sat8(d.m0h + floor_rnd(dhx * xc, lw) + floor_rnd(dvx * yc, ly));
    v = sat8(d.m0v + floor_rnd(dhy * xc, lw) + floor_rnd(dvy * yc, ly));
  endfunction

  function automatic void push_block(desc_t d);
    int nx = 1 << (clampl(d.lw) - 2);
    int ny = 1 << (clampl(d.lh) - 2);
    exp_t e;
    for (int y = 0; y < ny; y++)
      for (int x = 0; x < nx; x++) begin
        model(d, x, y, e.h, e.v);
        e.sx = x; e.sy = y; e.c = 0;
        e.last = (x == nx - 1) && (y == ny - 1);
        exp_q.push_back(e);
      end
  endfunction

  function automatic desc_t mk(bit m6, int lw, int lh, int m0h, int m0v,
                               int m1h, int m1v, int m2h, int m2v);
    desc_t d;
    d.mode6 = m6; d.lw = lw; d.lh = lh;
    d.m0h = m0h; d.m0v = m0v; d.m1h = m1h; d.m1v = m1v; d.m2h = m2h; d.m2v = m2v;
    return d;
  endfunction

  // Compare process: every handshake against the model, every stall for stability
  exp_t prev;
  bit   hold_pend = 0;
  always @(negedge clk) begin : cmp
    exp_t  e, a;
    desc_t cd;
    cyc++;
    if (rst) begin
      exp_q.delete();
      hold_pend = 0;
      check("in_ready_during_rst", in_ready, 0);
    end else begin
      a.h = int'(out_mv_h); a.v = int'(out_mv_v);
      a.sx = int'(out_sb_x); a.sy = int'(out_sb_y);
      a.last = out_last; a.c = cyc;
      if (hold_pend) begin
        check("hold_valid", out_valid, 1);
        check("hold_mv_h", a.h, prev.h);
        check("hold_mv_v", a.v, prev.v);
        check("hold_sb_x", a.sx, prev.sx);
        check("hold_sb_y", a.sy, prev.sy);
        check("hold_last", a.last, prev.last);
      end
      if (out_valid && !out_ready) stall_cnt++;
      if (out_valid && out_ready) begin
        check("output_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("mv_h", a.h, e.h);
          check("mv_v", a.v, e.v);
          check("sb_x", a.sx, e.sx);
          check("sb_y", a.sy, e.sy);
          check("last", a.last, e.last);
          obs_q.push_back(a);
          if (a.last) last_out_cyc = cyc;
        end
      end
      hold_pend = out_valid && !out_ready;
      prev = a;
      if (in_valid && in_ready) begin
        cd.mode6 = in_mode6;
        cd.lw = int'(in_log2_w); cd.lh = int'(in_log2_h);
        cd.m0h = int'(in_mv0_h); cd.m0v = int'(in_mv0_v);
        cd.m1h = int'(in_mv1_h); cd.m1v = int'(in_mv1_v);
        cd.m2h = int'(in_mv2_h); cd.m2v = int'(in_mv2_v);
        push_block(cd);
        last_gap = cyc - last_out_cyc;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rmode == 0) out_ready = 1'b1;
      else if (rmode == 1) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic set_desc(desc_t d);
    in_mode6  = d.mode6;
    in_log2_w = LW'(d.lw);    in_log2_h = LW'(d.lh);
    in_mv0_h  = WIDTH'(d.m0h); in_mv0_v = WIDTH'(d.m0v);
    in_mv1_h  = WIDTH'(d.m1h); in_mv1_v = WIDTH'(d.m1v);
    in_mv2_h  = WIDTH'(d.m2h); in_mv2_v = WIDTH'(d.m2v);
  endtask

  task automatic scramble();
    in_valid = 1'b0;
    set_desc(mk(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255)));
  endtask

  task automatic offer(desc_t d);
    bit ok = 0;
    @(posedge clk); #1;
    set_desc(d);
    in_valid = 1'b1;
    for (int t = 0; t < 3000 && !ok; t++) begin
      @(negedge clk); #1;
      if (in_ready) ok = 1;
    end
    check("accept_in_time", ok, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_obs(int n);
    for (int t = 0; t < 3000 && obs_q.size() < n; t++) begin
      @(negedge clk); #1;
    end
    check("outputs_in_time", obs_q.size() >= n, 1);
  endtask

  task automatic check_pos(int idx, int sx, int sy, bit last);
    check("obs_present", obs_q.size() > idx, 1);
    if (obs_q.size() > idx) begin
      check("obs_sb_x", obs_q[idx].sx, sx);
      check("obs_sb_y", obs_q[idx].sy, sy);
      check("obs_last", obs_q[idx].last, last);
    end
  endtask

  task automatic check_obs(int idx, int h, int v, int sx, int sy, bit last);
    check_pos(idx, sx, sy, last);
    if (obs_q.size() > idx) begin
      check("obs_mv_h", obs_q[idx].h, h);
      check("obs_mv_v", obs_q[idx].v, v);
    end
  endtask

  task automatic check_s1(int base);
    check_obs(base + 0, 6, 2, 0, 0, 0);
    check_obs(base + 1, 10, 2, 1, 0, 0);
    check_obs(base + 2, 6, 6, 0, 1, 0);
    check_obs(base + 3, 10, 6, 1, 1, 1);
  endtask

  task automatic check_outputs_zero();
    check("out_valid_zero", out_valid, 0);
    check("out_mv_h_zero", int'(out_mv_h), 0);
    check("out_mv_v_zero", int'(out_mv_v), 0);
    check("out_sb_x_zero", int'(out_sb_x), 0);
    check("out_sb_y_zero", int'(out_sb_y), 0);
    check("out_last_zero", out_last, 0);
  endtask

  initial begin
    desc_t d1, d2, d3, db, dr;
    int    h, v, base, s0;
    bit    idle_ok;

    rst = 1'b1; out_ready = 1'b1;
    scramble();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_outputs_zero();
    check("in_ready_in_rst", in_ready, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); #1;
    check("in_ready_idle", in_ready, 1);

    d1 = mk(0, 3, 3, 4, 0, 12, 0, 0, 0);
    d2 = mk(1, 3, 2, 0, 0, 8, 0, 0, 4);
    d3 = mk(0, 2, 2, 100, 0, 127, -128, 0, 0);
    model(d1, 0, 0, h, v); check("model_s1_h0", h, 6);   check("model_s1_v0", v, 2);
    model(d1, 1, 1, h, v); check("model_s1_h3", h, 10);  check("model_s1_v3", v, 6);
    model(d2, 1, 0, h, v); check("model_s2_h1", h, 6);   check("model_s2_v1", v, 2);
    model(d3, 0, 0, h, v); check("model_s3_h", h, 127);  check("model_s3_v", v, -50);

    // 4-parameter 8x8: latency, throughput, order
    base = obs_q.size();
    offer(d1); scramble();
    @(negedge clk); #1 check("latency_not_yet", out_valid, 0);
    @(negedge clk); #1 check("latency_sb0_valid", out_valid, 1);
    wait_obs(base + 4);
    @(negedge clk); #1 check("in_ready_after_s1", in_ready, 1);
    check_s1(base);
    if (obs_q.size() >= base + 4) check("s1_no_bubbles", obs_q[base + 3].c - obs_q[base].c, 3);

    // 6-parameter 8x4
    base = obs_q.size();
    offer(d2); scramble(); wait_obs(base + 2);
    check_obs(base + 0, 2, 2, 0, 0, 0);
    check_obs(base + 1, 6, 2, 1, 0, 1);

    // Saturation and rounding, single sub-block
    base = obs_q.size();
    offer(d3); scramble(); wait_obs(base + 1);
    check_obs(base, 127, -50, 0, 0, 1);
    @(negedge clk); #1 check("in_ready_after_s3", in_ready, 1);

    // Backpressure on sub-block 1
    rmode = 2; out_ready = 1'b1;
    base = obs_q.size(); s0 = stall_cnt;
    offer(d1); scramble(); wait_obs(base + 1);
    @(posedge clk); #1 out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_obs(base + 4);
    check("stall_cycles", stall_cnt - s0, 3);
    check("bp_output_count", obs_q.size() - base, 4);
    check_s1(base);
    rmode = 0;

    // Reset after the second output
    base = obs_q.size();
    offer(d1); scramble(); wait_obs(base + 2);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk); #1 check("in_ready_mid_rst", in_ready, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); #1;
    check_outputs_zero();
    check("in_ready_after_rst", in_ready, 1);
    check("no_output_after_rst", obs_q.size() - base, 2);
    base = obs_q.size();
    offer(d2); scramble(); wait_obs(base + 2);
    check_obs(base + 0, 2, 2, 0, 0, 0);
    check_obs(base + 1, 6, 2, 1, 0, 1);

    // Back-to-back descriptors, second one clamped to 32x4
    base = obs_q.size();
    db = mk(0, 7, 1, -20, 5, 30, -7, 0, 0);
    offer(d1); offer(db); scramble();
    check("b2b_accept_gap", last_gap, 1);
    wait_obs(base + 12);
    check_s1(base);
    for (int i = 0; i < 8; i++) check_pos(base + 4 + i, i, 0, i == 7);

    // Randomized descriptors with random backpressure
    rmode = 1;
    for (int b = 0; b < 40; b++) begin
      dr = mk(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 7),
              int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
              int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
              int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      offer(dr); scramble();
    end
    idle_ok = 0;
    for (int t = 0; t < 3000 && !idle_ok; t++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && in_ready) idle_ok = 1;
    end
    check("random_drained", idle_ok, 1);
    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
